atomic_ctrl: RTL
================

Name: atomic_ctrl

Overview:
- Sequencer for RV32A/RV64A instructions (AMO*, LR, SC) in the memory stage.
- Accepts one atomic request from the core and runs the read-modify-write on the data bus.
- Feeds an internally instantiated atomic_alu: s1 = register operand, s2 = loaded memory word. Writes alu_res back and returns the rd value.
- Holds the single LR/SC reservation for the hart.

Parameters:
- RSV_GRAN_BITS, 2: low address bits ignored in the reservation compare (granule = 2^RSV_GRAN_BITS bytes).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_start  in  1  request strobe; sampled only in IDLE
- i_funct5  in  5  RISC-V A-extension funct5 (AMO codes, LR=00010, SC=00011)
- i_addr  in  `XLEN  effective address (rs1)
- i_rs2  in  `XLEN  register operand
- i_rsv_clr  in  1  external reservation kill (trap, foreign store snoop)
- o_busy  out  1  high while not IDLE
- o_done  out  1  one-cycle completion pulse
- o_rd_data  out  `XLEN  rd result, valid when o_done
- o_misaligned  out  1  one-cycle misaligned-address pulse (see Optional Feature)
- o_bus_en  out  1  bus request
- o_bus_we  out  1  1 = write
- o_bus_addr  out  `XLEN  bus address
- o_bus_wdata  out  `XLEN  bus write data
- i_bus_rdata  in  `XLEN  bus read data, valid with ack on a read
- i_bus_ack  in  1  bus completion

Behaviour:
- Reset (async): state IDLE; all outputs 0; reservation invalid. Reset mid-operation drops o_bus_en immediately; the partial op is abandoned and nothing is written.
- States: IDLE, LOAD, STORE, DONE.
- IDLE:
  - On i_start, latch funct5, addr and rs2.
  - AMO or LR: go to LOAD.
  - SC with reservation valid and addr[`XLEN-1:RSV_GRAN_BITS] match: go to STORE.
  - SC otherwise: go to DONE with rd = 1 and no bus access.
- LOAD:
  - o_bus_en=1, we=0, addr=latched addr, held until i_bus_ack.
  - On ack, latch i_bus_rdata as old.
  - LR: set reservation to addr, rd = old, go to DONE.
  - AMO: go to STORE.
- STORE:
  - o_bus_en=1, we=1; wdata = alu_res(funct5, rs2, old) for AMO, rs2 for SC. Held until ack.
  - AMO: rd = old. SC: rd = 0.
  - Go to DONE.
- DONE: o_done=1 for exactly one cycle with o_rd_data; return to IDLE. o_rd_data holds until the next o_done.
- Bus request timing: o_bus_en deasserts the cycle after the ack edge. An ack while o_bus_en=0 is ignored. Bus outputs stay stable while waiting.
- Reservation clearing:
  - Any SC clears the reservation on the DONE transition, pass or fail.
  - i_rsv_clr clears it at the next edge. If i_rsv_clr and an SC compare coincide in IDLE, the SC fails.
  - If i_rsv_clr and LR completion coincide, the LR set wins.
- Latency, zero-wait-state bus (ack in the first request cycle):
  - AMO: start → done in 3 cycles.
  - LR: 2 cycles.
  - SC pass: 2 cycles.
  - SC fail: 1 cycle.
- Arithmetic: full `XLEN width, wrap-around on AMOADD; signed vs unsigned per atomic_alu. Unknown funct5 is treated as AMOSWAP.
- i_start while o_busy is ignored.

Optional Feature:
- Macro: ATOMIC_MISALIGN_TRAP_EN.
- Defined: in IDLE, an address not aligned to `XLEN/8 bytes goes straight to DONE; o_misaligned=1 together with o_done, rd = 0, no bus access, reservation unchanged.
- Undefined: o_misaligned is tied 0 and the low alignment bits of o_bus_addr are forced to 0.

Test Plan:
- AMOADD, addr 0x100, mem 0x7FFFFFFF, rs2 1, zero-wait bus → read then write 0x80000000; rd 0x7FFFFFFF; done 3 cycles after start.
- AMOMIN, mem 0xFFFFFFFE, rs2 5 → write 0xFFFFFFFE. AMOMINU, same operands → write 5. In both cases rd = 0xFFFFFFFE.
- LR 0x200 → rd = mem. Then SC 0x204, rs2 0xAB, RSV_GRAN_BITS=4 → write 0xAB to 0x204, rd 0. A second SC → rd 1 with no bus access.
- LR 0x300, pulse i_rsv_clr, SC 0x300 → rd 1, o_bus_en never asserted.
- AMOSWAP with ack delayed 4 cycles on both phases → o_bus_en, addr and wdata stable throughout; done 11 cycles after start. Assert rst during STORE → o_bus_en 0 immediately; state IDLE.
- ATOMIC_MISALIGN_TRAP_EN defined, AMOOR at 0x102 → o_misaligned and o_done in the cycle after start, no bus traffic. Undefined → bus addr 0x100.

Source files
------------

// File: rtl/atomic_ctrl.sv
// ---------------------------------------------------------------------------
// atomic_ctrl -- RV32A/RV64A atomic sequencer for the memory stage.
//
// Runs one AMO / LR / SC at a time as a read-modify-write on a simple
// request/ack data bus. It holds the hart's single LR/SC reservation.
// An internal atomic_alu combines the register operand (s1 = rs2) with the
// loaded memory word (s2).
//
// Optional feature macro: ATOMIC_MISALIGN_TRAP_EN
//   defined   : a misaligned address skips the bus, completes with
//               o_misaligned=1 and rd=0, and leaves the reservation as is.
//   undefined : o_misaligned is tied 0 and the low alignment bits of the
//               bus address are forced to 0.
//
// Ports:
//   clk, rst               clock, async active-high reset
//   i_start                request strobe (only looked at in IDLE)
//   i_funct5               A-extension funct5 (LR=00010, SC=00011)
//   i_addr, i_rs2          effective address, register operand
//   i_rsv_clr              external reservation kill
//   o_busy, o_done         busy while not IDLE; one-cycle done pulse
//   o_rd_data              rd result (held until the next o_done)
//   o_misaligned           misaligned-address pulse, with o_done
//   o_bus_*/i_bus_*        data bus request / response
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

// Combinational AMO datapath. Unknown codes fall back to swap.
module atomic_alu #(
    parameter int W = `XLEN
) (
    input  logic [4:0]   funct5,
    input  logic [W-1:0] s1,
    input  logic [W-1:0] s2,
    output logic [W-1:0] res
);
    always_comb begin
        res = s1;
        case (funct5)
            5'b00000: res = s1 + s2;
            5'b00100: res = s1 ^ s2;
            5'b01000: res = s1 | s2;
            5'b01100: res = s1 & s2;
            5'b10000: res = ($signed(s1) < $signed(s2)) ? s1 : s2;
            5'b10100: res = ($signed(s1) > $signed(s2)) ? s1 : s2;
            5'b11000: res = (s1 < s2) ? s1 : s2;
            5'b11100: res = (s1 > s2) ? s1 : s2;
            default:  res = s1;
        endcase
    end
endmodule

module atomic_ctrl #(
    parameter int RSV_GRAN_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [4:0]        i_funct5,
    input  logic [`XLEN-1:0]  i_addr,
    input  logic [`XLEN-1:0]  i_rs2,
    input  logic              i_rsv_clr,
    output logic              o_busy,
    output logic              o_done,
    output logic [`XLEN-1:0]  o_rd_data,
    output logic              o_misaligned,
    output logic              o_bus_en,
    output logic              o_bus_we,
    output logic [`XLEN-1:0]  o_bus_addr,
    output logic [`XLEN-1:0]  o_bus_wdata,
    input  logic [`XLEN-1:0]  i_bus_rdata,
    input  logic              i_bus_ack
);
    localparam int XW         = `XLEN;
    localparam int ALIGN_BITS = $clog2(XW / 8);
    localparam logic [XW-1:0] ALIGN_MASK = XW'((1 << ALIGN_BITS) - 1);
    localparam logic [4:0] F5_LR = 5'b00010;
    localparam logic [4:0] F5_SC = 5'b00011;

    typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

    state_t                   state, state_n;
    logic [4:0]               f5_q;
    logic [XW-1:0]            addr_q, rs2_q, old_q, rd_q;
    logic                     rsv_valid;
    logic [XW-1:RSV_GRAN_BITS] rsv_tag;

    logic                     rd_we, rsv_set, rsv_kill, sc_hit;
    logic [XW-1:0]            rd_n, alu_res;
`ifdef ATOMIC_MISALIGN_TRAP_EN
    logic                     misal_q, misal_n;
`endif

    atomic_alu #(.W(XW)) u_alu (
        .funct5 (f5_q),
        .s1     (rs2_q),
        .s2     (old_q),
        .res    (alu_res)
    );

    // An external kill in the same cycle as the compare makes the SC fail.
    assign sc_hit = rsv_valid && !i_rsv_clr &&
                    (i_addr[XW-1:RSV_GRAN_BITS] == rsv_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        rd_we    = 1'b0;
        rd_n     = '0;
        rsv_set  = 1'b0;
        rsv_kill = i_rsv_clr;
`ifdef ATOMIC_MISALIGN_TRAP_EN
        misal_n  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (i_start) begin
`ifdef ATOMIC_MISALIGN_TRAP_EN
                    if (|(i_addr & ALIGN_MASK)) begin
                        state_n  = DONE;
                        rd_we    = 1'b1;
                        misal_n  = 1'b1;
                    end else
`endif
                    if (i_funct5 == F5_SC) begin
                        if (sc_hit) begin
                            state_n = STORE;
                        end else begin
                            state_n  = DONE;
                            rd_we    = 1'b1;
                            rd_n     = XW'(1);
                            rsv_kill = 1'b1;
                        end
                    end else begin
                        state_n = LOAD;
                    end
                end
            end
            LOAD: begin
                if (i_bus_ack) begin
                    if (f5_q == F5_LR) begin
                        state_n = DONE;
                        rd_we   = 1'b1;
                        rd_n    = i_bus_rdata;
                        rsv_set = 1'b1;
                    end else begin
                        state_n = STORE;
                    end
                end
            end
            STORE: begin
                if (i_bus_ack) begin
                    state_n = DONE;
                    rd_we   = 1'b1;
                    if (f5_q == F5_SC) begin
                        rd_n     = '0;
                        rsv_kill = 1'b1;
                    end else begin
                        rd_n = old_q;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f5_q      <= '0;
            addr_q    <= '0;
            rs2_q     <= '0;
            old_q     <= '0;
            rd_q      <= '0;
            rsv_valid <= 1'b0;
            rsv_tag   <= '0;
`ifdef ATOMIC_MISALIGN_TRAP_EN
            misal_q   <= 1'b0;
`endif
        end else begin
            if (state == IDLE && i_start) begin
                f5_q    <= i_funct5;
                rs2_q   <= i_rs2;
`ifdef ATOMIC_MISALIGN_TRAP_EN
                addr_q  <= i_addr;
                misal_q <= misal_n;
`else
                addr_q  <= i_addr & ~ALIGN_MASK;
`endif
            end
            if (state == LOAD && i_bus_ack)
                old_q <= i_bus_rdata;
            if (rd_we)
                rd_q <= rd_n;
            // LR set beats a coincident external kill.
            if (rsv_set) begin
                rsv_valid <= 1'b1;
                rsv_tag   <= addr_q[XW-1:RSV_GRAN_BITS];
            end else if (rsv_kill) begin
                rsv_valid <= 1'b0;
            end
        end
    end

    assign o_busy      = (state != IDLE);
    assign o_done      = (state == DONE);
    assign o_rd_data   = rd_q;
    assign o_bus_en    = (state == LOAD) || (state == STORE);
    assign o_bus_we    = (state == STORE);
    assign o_bus_addr  = addr_q;
    assign o_bus_wdata = (state != STORE) ? '0 :
                         (f5_q == F5_SC)  ? rs2_q : alu_res;
`ifdef ATOMIC_MISALIGN_TRAP_EN
    assign o_misaligned = (state == DONE) && misal_q;
`else
    assign o_misaligned = 1'b0;
`endif
endmodule
